// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among C_NUM_REQ valid/ready requesters.
// Define FIFO_ARB_FIXED_PRIO_EN to make IDLE always pick the lowest-index valid requester.
module fifo_wr_arbiter #(
    parameter int C_NUM_REQ    = 4,
    parameter int C_DATA_WIDTH = 8,
    parameter int C_BURST_LEN  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_NUM_REQ-1:0]              req_valid,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_data,
    output logic [C_NUM_REQ-1:0]              req_ready,
    input  logic                              fifo_full,
    output logic                              fifo_wr_en,
    output logic [C_DATA_WIDTH-1:0]           fifo_din,
    output logic [$clog2(C_NUM_REQ)-1:0]      grant_idx,
    output logic                              busy
);

    localparam int unsigned NREQ  = C_NUM_REQ;
    localparam int          IDX_W = $clog2(C_NUM_REQ);
    localparam int          CNT_W = $clog2(C_BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(C_BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]        beat_q, beat_d;

    logic                    cur_valid;
    logic [C_DATA_WIDTH-1:0] cur_data;
    logic                    found;
    logic [IDX_W-1:0]        sel;
    int unsigned             cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= IDX_W'(C_NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_d     = beat_q;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        cur_valid  = 1'b0;
        cur_data   = '0;
        found      = 1'b0;
        sel        = '0;
        cand       = 0;

        for (int unsigned j = 0; j < NREQ; j++) begin
            if (IDX_W'(j) == grant_q) begin
                cur_valid = req_valid[j];
                cur_data  = req_data[j*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end

`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && req_valid[j]) begin
                found = 1'b1;
                sel   = IDX_W'(j);
            end
        end
`else
        // Candidates are visited in distance order from the last grantee, so the modulo wrap
        // also holds when C_NUM_REQ is not a power of two.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(grant_q) + k) % NREQ;
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && (j == cand) && req_valid[j]) begin
                    found = 1'b1;
                    sel   = IDX_W'(j);
                end
            end
        end
`endif

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = sel;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if (IDX_W'(j) == grant_q) req_ready[j] = ~fifo_full;
                end
                if (!cur_valid) begin
                    state_d = IDLE;
                end else if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = cur_data;
                    beat_d     = beat_q + CNT_W'(1);
                    if (beat_q == LAST_BEAT) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences and random traffic vs a reference model.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_din;
    logic [1:0]     grant_idx;
    logic           busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .C_NUM_REQ   (N),
        .C_DATA_WIDTH(W),
        .C_BURST_LEN (B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whether a grant is open, words taken in it.
    int m_owner  = N - 1;
    bit m_active = 1'b0;
    int m_taken  = 0;

    function automatic int pick(input logic [N-1:0] v);
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(m_owner + k) % N]) return (m_owner + k) % N;
`endif
        return -1;
    endfunction

    // Requester word stores
    logic [7:0]   mem [N][256];
    int           hd [N];
    int           tl [N];
    logic [N-1:0] ven = '0;
    bit           full_drv = 1'b0;
    bit           rst_drv = 1'b0;
    int           n_acc = 0;
    int           n_wr = 0;

    int glog [64];
    int gcnt = 0;
    bit prev_busy = 1'b0;

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        gcnt = 0;
    endtask

    task automatic load(input int r, input int cnt, input logic [7:0] base);
        for (int k = 0; k < cnt; k++) begin
            mem[r][tl[r]] = base + 8'(k);
            tl[r]++;
        end
    endtask

    task automatic apply(input logic r, input logic f, input logic [N-1:0] v, input logic [N*W-1:0] d);
        @(negedge clk);
        rst       = r;
        fifo_full = f;
        req_valid = v;
        req_data  = d;
        #1;
    endtask

    task automatic drive_q();
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) begin
            v[i]       = ven[i] && (hd[i] < tl[i]);
            d[i*W +: W] = (hd[i] < tl[i]) ? mem[i][hd[i]] : 8'h00;
        end
        apply(rst_drv, full_drv, v, d);
    endtask

    task automatic check_model();
        logic [N-1:0] er;
        logic         ew;
        logic [7:0]   ed;
        er = '0;
        ew = 1'b0;
        ed = 8'h00;
        if (m_active) begin
            if (!fifo_full) er[m_owner] = 1'b1;
            ew = req_valid[m_owner] && !fifo_full;
            if (ew) ed = req_data[m_owner*W +: W];
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(ew));
        chk("fifo_din", 32'(fifo_din), 32'(ed));
        chk("grant_idx", 32'(grant_idx), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_active));
        chk("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'h0);
        if (busy && !prev_busy && gcnt < 64) begin
            glog[gcnt] = int'(grant_idx);
            gcnt++;
        end
        prev_busy = busy;
    endtask

    task automatic edge_update();
        logic [N-1:0] acc;
        logic         wr;
        int           p;
        acc = req_valid & req_ready;
        wr  = fifo_wr_en;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0;
            m_owner  = N - 1;
            m_taken  = 0;
        end else if (!m_active) begin
            p = pick(req_valid);
            if (p >= 0) begin
                m_owner  = p;
                m_active = 1'b1;
                m_taken  = 0;
            end
        end else if (!req_valid[m_owner]) begin
            m_active = 1'b0;
        end else if (!fifo_full) begin
            m_taken++;
            if (m_taken == B) m_active = 1'b0;
        end
        for (int i = 0; i < N; i++) if (acc[i]) hd[i]++;
        n_acc += $countones(acc);
        if (wr) n_wr++;
        #1;
    endtask

    task automatic step();
        drive_q();
        check_model();
        edge_update();
    endtask

    task automatic do_reset();
        clear_q();
        ven      = '0;
        full_drv = 1'b0;
        rst_drv  = 1'b1;
        step();
        rst_drv  = 1'b0;
    endtask

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [31:0] d;
        logic       f;
        logic [3:0] er;
        logic       ew;
        logic [7:0] ed;
        logic [1:0] eg;
        logic       eb;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [31:0] d2(input logic [7:0] b);
        return {8'h00, b, 16'h0000};
    endfunction

    initial begin
        // Requester 2 alone with words 0x10..0x17: two 4-word bursts split by one IDLE cycle.
        tbl[0]  = '{1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, d2(8'h10), 1'b0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};
        for (int k = 0; k < 4; k++) begin
            tbl[2+k] = '{1'b0, 4'b0100, d2(8'h10 + 8'(k)), 1'b0, 4'b0100, 1'b1, 8'h10 + 8'(k), 2'd2, 1'b1};
            tbl[7+k] = '{1'b0, 4'b0100, d2(8'h14 + 8'(k)), 1'b0, 4'b0100, 1'b1, 8'h14 + 8'(k), 2'd2, 1'b1};
        end
        tbl[6]  = '{1'b0, 4'b0100, d2(8'h14), 1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};
        tbl[11] = '{1'b0, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};

        clear_q();
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, 1'b0, '0, '0);
            edge_update();
        end
        for (int k = 0; k < 12; k++) begin
            apply(tbl[k].r, tbl[k].f, tbl[k].v, tbl[k].d);
            chk($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(tbl[k].er));
            chk($sformatf("tbl%0d_wr_en", k), 32'(fifo_wr_en), 32'(tbl[k].ew));
            chk($sformatf("tbl%0d_din", k), 32'(fifo_din), 32'(tbl[k].ed));
            chk($sformatf("tbl%0d_grant", k), 32'(grant_idx), 32'(tbl[k].eg));
            chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].eb));
            edge_update();
        end

        // All requesters continuously valid
        do_reset();
        for (int i = 0; i < N; i++) load(i, 20, 8'(i * 32));
        ven = 4'b1111;
        for (int c = 0; c < 30; c++) step();
        chk("fair_grant_count", 32'(gcnt >= 5), 32'h1);
        for (int g = 0; g < 5; g++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
            chk($sformatf("fair_grant%0d", g), 32'(glog[g]), 32'd0);
`else
            chk($sformatf("fair_grant%0d", g), 32'(glog[g]), 32'(g % N));
`endif
        end

        // Full stall after the second word of a burst
        do_reset();
        load(1, 8, 8'h20);
        ven = 4'b0010;
        for (int t = 0; t < 10 && !(m_active && m_taken == 2); t++) step();
        chk("stall_reach_word3", 32'(busy), 32'h1);
        full_drv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_q();
            check_model();
            chk("stall_ready0", 32'(req_ready), 32'h0);
            chk("stall_grant_held", 32'(busy), 32'h1);
            edge_update();
        end
        full_drv = 1'b0;
        for (int c = 0; c < 12; c++) step();
        chk("stall_all_words", 32'(hd[1]), 32'd8);

        // Early release by requester 1 after two words
        do_reset();
        load(1, 2, 8'h30);
        load(2, 4, 8'h40);
        ven = 4'b0110;
        for (int c = 0; c < 14; c++) step();
        chk("early_grant0", 32'(glog[0]), 32'd1);
        chk("early_grant1", 32'(glog[1]), 32'd2);
        chk("early_req1_words", 32'(hd[1]), 32'd2);
        chk("early_req2_words", 32'(hd[2]), 32'd4);

        // Reset during the third word of a burst
        do_reset();
        load(0, 8, 8'h50);
        ven = 4'b0001;
        for (int t = 0; t < 10 && !(m_active && m_taken == 2); t++) step();
        chk("rst_reach_word3", 32'(busy), 32'h1);
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        drive_q();
        check_model();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("rst_grant", 32'(grant_idx), 32'd3);
        edge_update();
        drive_q();
        check_model();
        chk("rst_regrant0", 32'(grant_idx), 32'd0);
        edge_update();
        for (int c = 0; c < 12; c++) step();

        // Requesters 1 and 3 continuously valid
        do_reset();
        load(1, 20, 8'h60);
        load(3, 20, 8'h80);
        ven = 4'b1010;
        for (int c = 0; c < 20; c++) step();
        for (int g = 0; g < 4; g++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
            chk($sformatf("prio_grant%0d", g), 32'(glog[g]), 32'd1);
`else
            chk($sformatf("prio_grant%0d", g), 32'(glog[g]), (g % 2 == 0) ? 32'd1 : 32'd3);
`endif
        end

        // Random traffic, stalls and occasional resets
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hd[i] == tl[i]) begin
                    hd[i] = 0;
                    tl[i] = 0;
                    if ($urandom_range(0, 2) != 0) load(i, $urandom_range(1, 10), 8'($urandom));
                end
                ven[i] = ($urandom_range(0, 9) < 8);
            end
            full_drv = ($urandom_range(0, 3) == 0);
            rst_drv  = ($urandom_range(0, 149) == 0);
            step();
        end
        rst_drv = 1'b0;
        chk("words_written_vs_accepted", 32'(n_wr), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
